md_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers, driven from the EX stage.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Produces the isbusy signal that the hazard/stall unit combines with RHL_visit to freeze IF/ID while an HI/LO consumer waits.
- hi/lo outputs feed the EX-stage MFHI/MFLO source mux.

---
 rtl/md_pkg.sv | 18 +
 rtl/md_datapath.sv | 62 ++++++
 rtl/md_unit.sv | 76 +++++++
 tb/tb_md_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared op/state encodings and datapath width for the multiply/divide unit
package md_pkg;
   localparam int WIDTH = 32;
   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;
   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } md_state_e;
endpackage

// File: rtl/md_datapath.sv
// md_datapath: operand magnitudes, shift-add multiply / restoring divide iteration and sign fix
module md_datapath
   import md_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   logic [WIDTH-1:0]   a_q, b_q;
   logic [2*WIDTH-1:0] acc_q;
   logic               sa_q, sb_q, div_q;
   logic               signed_op, div_op, neg_a, neg_b;
   logic [WIDTH:0]     mul_sum, div_sh;
   logic [WIDTH+1:0]   div_diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;
   assign signed_op = op_i == MD_MULT || op_i == MD_DIV;
   assign div_op    = op_i == MD_DIV || op_i == MD_DIVU;
   assign neg_a     = signed_op & a_i[WIDTH-1];
   assign neg_b     = signed_op & b_i[WIDTH-1];
   // one iteration of each algorithm plus the final sign correction
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q[0] ? a_q : '0};
      div_sh   = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
      div_diff = {1'b0, div_sh} - {2'b0, b_q};
      prod     = (sa_q ^ sb_q) ? -acc_q : acc_q;
      quo      = (sa_q ^ sb_q) ? -a_q : a_q;
      rem      = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      hi_o     = div_q ? rem : prod[2*WIDTH-1:WIDTH];
      lo_o     = div_q ? quo : prod[WIDTH-1:0];
   end
   // latch magnitudes at accept, then shift/accumulate once per CALC cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         sa_q  <= 1'b0;
         sb_q  <= 1'b0;
         div_q <= 1'b0;
      end else if (load_i) begin
         a_q   <= neg_a ? -a_i : a_i;
         b_q   <= neg_b ? -b_i : b_i;
         acc_q <= '0;
         sa_q  <= neg_a;
         sb_q  <= neg_b;
         div_q <= div_op;
      end else if (step_i && div_q) begin
         acc_q <= {{(WIDTH-1){1'b0}}, div_diff[WIDTH+1] ? div_sh : div_diff[WIDTH:0]};
         a_q   <= {a_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
      end else if (step_i) begin
         acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
         b_q   <= b_q >> 1;
      end
   end
endmodule

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit with HI/LO registers, busy flag and early-flush abort
module md_unit #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             flush,
   output logic             isbusy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   import md_pkg::*;
   localparam int CW = $clog2(ITER);
   md_state_e        state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, res_hi, res_lo;
   logic             accept, mt_op, md_accept, abort, step;
   assign accept    = state_q == IDLE && start && op != MD_NONE && op != 3'b111 && !flush;
   assign mt_op     = op == MD_MTHI || op == MD_MTLO;
   assign md_accept = accept && !mt_op;
   assign abort     = state_q == CALC && flush && count_q == '0;
   assign step      = state_q == CALC && !abort;
   assign isbusy    = state_q != IDLE;
   assign hi        = hi_q;
   assign lo        = lo_q;
   md_datapath u_dp (
      .clk    (clk),
      .rst    (rst),
      .load_i (md_accept),
      .step_i (step),
      .op_i   (op),
      .a_i    (rs_data),
      .b_i    (rt_data),
      .hi_o   (res_hi),
      .lo_o   (res_lo)
   );
   // next state, iteration count and HI/LO updates
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      hi_d    = (accept && op == MD_MTHI) ? rs_data : hi_q;
      lo_d    = (accept && op == MD_MTLO) ? rs_data : lo_q;
      if (md_accept) begin
         state_d = CALC;
         count_d = '0;
      end
      if (state_q == CALC) begin
         count_d = count_q + 1'b1;
         state_d = abort ? IDLE : (count_q == CW'(ITER-1)) ? FIX : CALC;
      end
      if (state_q == FIX) begin
         state_d = IDLE;
         hi_d    = res_hi;
         lo_d    = res_lo;
      end
   end
   // state, counter and architectural HI/LO registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit
module tb_md_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        flush = 1'b0;
   logic        isbusy;
   logic [31:0] hi, lo;
   int          checks = 0;
   int          errors = 0;

   localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4,
                          OP_MTHI = 3'd5, OP_MTLO = 3'd6;

   md_unit dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .flush   (flush),
      .isbusy  (isbusy),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   // called at a negedge; presents the op for one posedge and returns at the next negedge
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      @(negedge clk);
      start = 1'b0; op = 3'd0;
   endtask

   // counts busy cycles until isbusy falls, bounded
   task automatic wait_idle(inout int busy);
      while (isbusy && busy < 100) begin
         busy++;
         @(negedge clk);
      end
      if (isbusy) begin
         errors++;
         $display("FAIL timeout busy=%0d required idle", busy);
      end
   endtask

   task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int busy);
      issue(o, a, b);
      busy = 0;
      wait_idle(busy);
   endtask

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h required=%h", name, got, exp);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (isbusy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", isbusy); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h required=0", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h required=0", lo); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mult;
      int busy;
      run_md(OP_MULT, 32'hFFFFFFFD, 32'h00000005, busy);
      checks++; if (busy !== 33) begin errors++; $display("FAIL mult_busy got=%0d required=33", busy); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h required=FFFFFFFF", hi); end
      checks++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo got=%h required=FFFFFFF1", lo); end
      run_md(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, busy);
      checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got=%h required=FFFFFFFE", hi); end
      checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got=%h required=00000001", lo); end
   endtask

   task automatic test_div;
      int busy;
      run_md(OP_DIV, 32'hFFFFFFF9, 32'h00000002, busy);
      checks++; if (busy !== 33) begin errors++; $display("FAIL div_busy got=%0d required=33", busy); end
      checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got=%h required=FFFFFFFD", lo); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got=%h required=FFFFFFFF", hi); end
      run_md(OP_DIVU, 32'h00000007, 32'h00000000, busy);
      checks++; if (hi !== 32'h00000007) begin errors++; $display("FAIL divu0_hi got=%h required=00000007", hi); end
      checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_lo got=%h required=FFFFFFFF", lo); end
      run_md(OP_DIV, 32'h80000000, 32'hFFFFFFFF, busy);
      checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL divwrap_lo got=%h required=80000000", lo); end
      checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL divwrap_hi got=%h required=00000000", hi); end
      run_md(OP_DIV, 32'hFFFFFFFB, 32'h00000000, busy);
      checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL divneg0_lo got=%h required=00000001", lo); end
      checks++; if (hi !== 32'hFFFFFFFB) begin errors++; $display("FAIL divneg0_hi got=%h required=FFFFFFFB", hi); end
      run_md(OP_DIV, 32'h00000064, 32'hFFFFFFF9, busy);
      checks++; if (lo !== 32'hFFFFFFF2) begin errors++; $display("FAIL divposneg_lo got=%h required=FFFFFFF2", lo); end
      checks++; if (hi !== 32'h00000002) begin errors++; $display("FAIL divposneg_hi got=%h required=00000002", hi); end
   endtask

   task automatic test_mt;
      int busy;
      issue(OP_MTHI, 32'h12345678, 32'h0);
      checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got=%h required=12345678", hi); end
      checks++; if (isbusy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b required=0", isbusy); end
      issue(OP_MTLO, 32'hAAAA5555, 32'h0);
      checks++; if (lo !== 32'hAAAA5555) begin errors++; $display("FAIL mtlo_lo got=%h required=AAAA5555", lo); end
      issue(OP_MULTU, 32'h00000002, 32'h00000003);
      repeat (3) @(negedge clk);
      issue(OP_MTLO, 32'hDEADBEEF, 32'h0);
      checks++; if (lo !== 32'hAAAA5555) begin errors++; $display("FAIL mtlo_busy_lo got=%h required=AAAA5555", lo); end
      busy = 0;
      wait_idle(busy);
      checks++; if (lo !== 32'h00000006) begin errors++; $display("FAIL mtlo_after_lo got=%h required=00000006", lo); end
      checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL mtlo_after_hi got=%h required=00000000", hi); end
   endtask

   task automatic test_flush;
      int busy;
      issue(OP_MTHI, 32'h11111111, 32'h0);
      issue(OP_MTLO, 32'h22222222, 32'h0);
      flush = 1'b1;
      issue(OP_DIVU, 32'h00000064, 32'h00000007);
      flush = 1'b0;
      checks++; if (isbusy !== 1'b0) begin errors++; $display("FAIL flush_accept_busy got=%b required=0", isbusy); end
      issue(OP_DIVU, 32'h00000064, 32'h00000007);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++; if (isbusy !== 1'b0) begin errors++; $display("FAIL flush0_busy got=%b required=0", isbusy); end
      check32("flush0_hi", hi, 32'h11111111);
      check32("flush0_lo", lo, 32'h22222222);
      issue(OP_DIVU, 32'h00000064, 32'h00000007);
      busy = 0;
      repeat (5) begin
         if (isbusy) busy++;
         @(negedge clk);
      end
      flush = 1'b1;
      busy++;
      @(negedge clk);
      flush = 1'b0;
      wait_idle(busy);
      checks++; if (busy !== 33) begin errors++; $display("FAIL flush5_busy got=%0d required=33", busy); end
      check32("flush5_hi", hi, 32'h00000002);
      check32("flush5_lo", lo, 32'h0000000E);
   endtask

   task automatic test_reset_mid;
      int busy;
      issue(OP_MULT, 32'h00000007, 32'h00000009);
      repeat (9) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checks++; if (isbusy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b required=0", isbusy); end
      check32("rstmid_hi", hi, 32'h0);
      check32("rstmid_lo", lo, 32'h0);
      run_md(OP_MULTU, 32'h00000002, 32'h00000003, busy);
      check32("rstmid_multu_hi", hi, 32'h0);
      check32("rstmid_multu_lo", lo, 32'h00000006);
   endtask

   task automatic test_back_to_back;
      int busy;
      run_md(OP_MULTU, 32'h00010000, 32'h00010000, busy);
      check32("b2b_mul_hi", hi, 32'h00000001);
      check32("b2b_mul_lo", lo, 32'h00000000);
      run_md(OP_DIVU, 32'hFFFFFFFF, 32'h00000010, busy);
      checks++; if (busy !== 33) begin errors++; $display("FAIL b2b_busy got=%0d required=33", busy); end
      check32("b2b_div_lo", lo, 32'h0FFFFFFF);
      check32("b2b_div_hi", hi, 32'h0000000F);
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_mult;
      test_div;
      test_mt;
      test_flush;
      test_reset_mid;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
